// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - UART receiver, word FIFO and transmitter echoing good frames
module uart_echo_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          uart_rxd,
  output logic          uart_txd,
  output logic          frame_err,
  output logic          parity_err,
  output logic          rx_overflow,
  output logic [AW:0]   fifo_level
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(STOP_BITS * BPS_CNT + 1);
  localparam logic [CW-1:0] HALF     = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] BIT_END  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * BPS_CNT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic          HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  // Odd parity makes data+parity carry an odd count of ones; even the opposite.
  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  logic [2:0]           rx_sync_q;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_stop_q, rx_stop_d;
  logic                 rx_done_q, rx_done_d;

  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 txd_q, txd_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rdata_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          level_q, level_d;

  logic rx_bit, rx_fall, par_bad, wr_req, fifo_full, fifo_rd, fifo_wr;

  assign rx_bit  = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

  // A finished frame is judged in the cycle after the stop-bit sample.
  assign par_bad     = HAS_PAR & (rx_par_q != calc_par(rx_data_q));
  assign frame_err   = rx_done_q & ~rx_stop_q;
  assign parity_err  = rx_done_q & rx_stop_q & par_bad;
  assign wr_req      = rx_done_q & rx_stop_q & ~par_bad;
  assign fifo_full   = (level_q == FULL_LVL);
  assign fifo_rd     = (tx_state_q == TX_IDLE) && (level_q != '0);
  assign fifo_wr     = wr_req & (~fifo_full | fifo_rd);
  assign rx_overflow = wr_req & fifo_full & ~fifo_rd;
  assign fifo_level  = level_q;
  assign uart_txd    = txd_q;

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rx_sync_q <= 3'b111;
    else            rx_sync_q <= {rx_sync_q[1:0], uart_rxd};
  end

  // RX next state: sample each bit at mid-bit, counting from the start-bit midpoint.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_stop_d  = rx_stop_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d  = '0;
          rx_data_d = {rx_bit, rx_data_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_PAR: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_bit;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_stop_d  = rx_bit;
          rx_done_d  = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_stop_q  <= 1'b1;
      rx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
      rx_stop_q  <= rx_stop_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // FIFO storage and registered read port; contents need no reset.
  always_ff @(posedge sys_clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= rx_data_q;
    if (fifo_rd) rdata_q <= mem[rd_ptr_q];
  end

  // Occupancy: a simultaneous write and read leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // TX next state; the line value is derived from the next state so txd is registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (level_q != '0) tx_state_d = TX_LOAD;
      end
      TX_LOAD: begin
        tx_cnt_d   = '0;
        tx_data_d  = rdata_q;
        tx_state_d = TX_START;
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) tx_state_d = HAS_PAR ? TX_PAR : TX_STOP;
          else                      tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_PAR: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == STOP_END) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_data_d[tx_bit_d];
      TX_PAR:   txd_d = calc_par(tx_data_d);
      default:  txd_d = 1'b1;
    endcase
  end

  // TX state registers; reset forces the line idle immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb/tb_uart_echo_fifo.sv - directed bench for uart_echo_fifo in 8N1, 7E1 and 8N2/depth-4 setups
module tb_uart_echo_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rxd = 3'b111;
  wire  [2:0] txd, ferr, perr, ovf;
  wire  [4:0] lvl_a, lvl_b;
  wire  [2:0] lvl_c;

  int checks = 0;
  int failures = 0;
  int ferr_cnt[3] = '{0, 0, 0};
  int perr_cnt[3] = '{0, 0, 0};
  int ovf_cnt[3]  = '{0, 0, 0};
  int nz_a = 0;
  int nz_b = 0;
  int max_c = 0;

  always #5 clk = ~clk;

  uart_echo_fifo #(.CLK_FREQ(1000000), .UART_BPS(100000)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[0]), .uart_txd(txd[0]),
    .frame_err(ferr[0]), .parity_err(perr[0]), .rx_overflow(ovf[0]), .fifo_level(lvl_a));

  uart_echo_fifo #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(7), .PARITY(2)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[1]), .uart_txd(txd[1]),
    .frame_err(ferr[1]), .parity_err(perr[1]), .rx_overflow(ovf[1]), .fifo_level(lvl_b));

  uart_echo_fifo #(.CLK_FREQ(1000000), .UART_BPS(100000), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[2]), .uart_txd(txd[2]),
    .frame_err(ferr[2]), .parity_err(perr[2]), .rx_overflow(ovf[2]), .fifo_level(lvl_c));

  // Pulse/level monitors: a pulse held two cycles counts twice.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ferr[i]) ferr_cnt[i] <= ferr_cnt[i] + 1;
      if (perr[i]) perr_cnt[i] <= perr_cnt[i] + 1;
      if (ovf[i])  ovf_cnt[i]  <= ovf_cnt[i] + 1;
    end
    if (lvl_a != 0) nz_a <= nz_a + 1;
    if (lvl_b != 0) nz_b <= nz_b + 1;
    if (int'(lvl_c) > max_c) max_c <= int'(lvl_c);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame, 10 clocks per bit, LSB first; bits holds data then any parity bit.
  task automatic send(input int d, input logic [8:0] bits, input int nb, input logic stopv);
    rxd[d] = 1'b0;
    tick(10);
    for (int i = 0; i < nb; i++) begin
      rxd[d] = bits[i];
      tick(10);
    end
    rxd[d] = stopv;
    tick(10);
    rxd[d] = 1'b1;
  endtask

  // Wait (bounded) for a start bit, then sample each bit near its middle.
  task automatic recv(input int d, input int nb, input int tmo,
                      output logic [8:0] bits, output logic got, output logic stopok);
    int w;
    bits = '0;
    got = 1'b0;
    stopok = 1'b0;
    w = 0;
    while (txd[d] !== 1'b0 && w < tmo) begin
      tick(1);
      w++;
    end
    if (txd[d] === 1'b0) begin
      got = 1'b1;
      tick(5);
      for (int i = 0; i < nb; i++) begin
        tick(10);
        bits[i] = txd[d];
      end
      tick(10);
      stopok = txd[d];
    end
  endtask

  initial begin
    logic [8:0] rb;
    logic       rg, rs;
    int         w, base, base2, last, ecnt, bad;

    // Reset state
    tick(3);
    chk("rst_txd", txd, 3'b111);
    chk("rst_lvl_a", lvl_a, 0);
    chk("rst_lvl_c", lvl_c, 0);
    chk("rst_flags", {ferr, perr, ovf}, 0);
    rst_n = 1'b1;
    tick(5);

    // 8N1 echo of 0x55 with read/start timing relative to the level rise
    fork
      send(0, 9'h055, 8, 1'b1);
      begin
        w = 0;
        while (lvl_a == 0 && w < 300) begin
          tick(1);
          w++;
        end
        chk("t1_level_rise", lvl_a, 1);
        chk("t1_txd_read_cycle", txd[0], 1);
        tick(1);
        chk("t1_level_after_read", lvl_a, 0);
        chk("t1_txd_load_cycle", txd[0], 1);
        tick(1);
        chk("t1_txd_start", txd[0], 0);
        recv(0, 8, 5, rb, rg, rs);
        chk("t1_echo_data", rb, 9'h055);
        chk("t1_echo_stop", rs, 1);
      end
    join

    // 7E1: 0x03 has two ones, so even parity bit is 0
    fork
      send(1, 9'h003, 8, 1'b1);
      recv(1, 8, 400, rb, rg, rs);
    join
    chk("t2_echo_got", rg, 1);
    chk("t2_echo_data_par", rb, 9'h003);
    chk("t2_echo_stop", rs, 1);
    base = perr_cnt[1];
    base2 = nz_b;
    fork
      send(1, 9'h083, 8, 1'b1);
      recv(1, 8, 250, rb, rg, rs);
    join
    tick(2);
    chk("t2_parity_err_pulses", perr_cnt[1] - base, 1);
    chk("t2_bad_par_no_echo", rg, 0);
    chk("t2_bad_par_level_zero", nz_b - base2, 0);

    // Frame error on 0xA5, then a good 0x3C
    base = ferr_cnt[0];
    fork
      send(0, 9'h0A5, 8, 1'b0);
      recv(0, 8, 250, rb, rg, rs);
    join
    tick(2);
    chk("t3_frame_err_pulses", ferr_cnt[0] - base, 1);
    chk("t3_frame_err_no_echo", rg, 0);
    fork
      send(0, 9'h03C, 8, 1'b1);
      recv(0, 8, 400, rb, rg, rs);
    join
    chk("t3_echo_after_ferr", rb, 9'h03C);
    chk("t3_echo_after_ferr_stop", rs, 1);

    // 3-clock low glitch: no write, no flag, receiver still usable
    base = ferr_cnt[0] + perr_cnt[0] + ovf_cnt[0];
    base2 = nz_a;
    rxd[0] = 1'b0;
    tick(3);
    rxd[0] = 1'b1;
    recv(0, 8, 150, rb, rg, rs);
    chk("t4_glitch_no_echo", rg, 0);
    chk("t4_glitch_no_flags", ferr_cnt[0] + perr_cnt[0] + ovf_cnt[0] - base, 0);
    chk("t4_glitch_no_write", nz_a - base2, 0);
    fork
      send(0, 9'h096, 8, 1'b1);
      recv(0, 8, 400, rb, rg, rs);
    join
    chk("t4_echo_after_glitch", rb, 9'h096);

    // 200 back-to-back bytes into a depth-4, two-stop-bit echo
    base = ovf_cnt[2];
    last = -1;
    ecnt = 0;
    bad = 0;
    fork
      for (int i = 0; i < 200; i++) send(2, 9'(i), 8, 1'b1);
      begin
        rg = 1'b1;
        while (rg) begin
          recv(2, 8, 400, rb, rg, rs);
          if (rg) begin
            if (int'(rb) <= last || rs !== 1'b1) bad++;
            last = int'(rb);
            ecnt++;
          end
        end
      end
    join
    chk("t5_max_level_le_4", max_c <= 4, 1);
    chk("t5_overflow_seen", (ovf_cnt[2] - base) >= 1, 1);
    chk("t5_order_errors", bad, 0);
    chk("t5_ovf_plus_echo", (ovf_cnt[2] - base) + ecnt, 200);

    // Reset mid TX data bit while a word waits in the FIFO
    fork
      for (int i = 0; i < 5; i++) send(2, 9'h000, 8, 1'b1);
      begin
        w = 0;
        while (!(lvl_c != 0 && txd[2] === 1'b0) && w < 2000) begin
          tick(1);
          w++;
        end
        chk("t6_busy_before_reset", (lvl_c != 0 && txd[2] === 1'b0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_txd_async_reset", txd[2], 1);
        chk("t6_level_async_reset", lvl_c, 0);
        tick(3);
        rst_n = 1'b1;
      end
    join
    tick(1500);
    fork
      send(2, 9'h081, 8, 1'b1);
      recv(2, 8, 400, rb, rg, rs);
    join
    chk("t6_echo_after_reset", rb, 9'h081);
    chk("t6_echo_after_reset_stop", rs, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
